// File: rtl/csidh_modred_seq.sv
// Streaming final reduction for CSIDH-512 elements (9 x 57-bit limbs): takes a in [0, 2p),
// subtracts p with borrow propagation, then adds p back under the sign mask, emitting a mod p.
module csidh_modred_seq #(
    parameter int NLIMB = 9,
    parameter int RADIX = 57
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_limb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_limb,
    output logic        out_last
);

    localparam logic [63:0] LIMB_MASK = (64'd1 << RADIX) - 64'd1;
    localparam logic [3:0]  LAST_IDX  = 4'(NLIMB - 1);

    typedef enum logic {
        S_SUB = 1'b0,
        S_ADD = 1'b1
    } state_t;

    function automatic logic [63:0] p_limb(input logic [3:0] idx);
        logic [63:0] v;
        case (idx)
            4'd0:    v = 64'h0181B90533C6C87B;
            4'd1:    v = 64'h010DFA2BD6541A8D;
            4'd2:    v = 64'h003307C2D3C9709C;
            4'd3:    v = 64'h00ACFE6AA0EA2CE6;
            4'd4:    v = 64'h01322C9CDA7AAC6C;
            4'd5:    v = 64'h00446212D7DFE634;
            4'd6:    v = 64'h01312AD0B420EBB7;
            4'd7:    v = 64'h017FF91561A2BC7C;
            4'd8:    v = 64'h0065B48E8F740F89;
            default: v = 64'h0000000000000000;
        endcase
        return v;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [63:0] c_r, c_nxt_s;
    logic [63:0] m_r, m_nxt_s;
    logic [63:0] buf_r [NLIMB];
    logic        in_ready_r, in_ready_nxt_s;
    logic        out_valid_r, out_valid_nxt_s;
    logic        out_last_r, out_last_nxt_s;
    logic [63:0] out_limb_r, out_limb_nxt_s;

    logic        buf_we_s;
    logic [63:0] buf_wdata_s;
    logic [63:0] p_cur_s;
    logic [63:0] t_s;
    logic [63:0] u_s;
    logic [63:0] c_sub_s;
    logic [63:0] c_add_s;
    logic [63:0] m_new_s;
    logic [3:0]  idx_nxt_s;
    logic [63:0] u_nxt_s;
    logic [63:0] u_first_s;

    // Datapath and next-state: outputs are precomputed one cycle ahead so they come from flops.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        c_nxt_s         = c_r;
        m_nxt_s         = m_r;
        in_ready_nxt_s  = in_ready_r;
        out_valid_nxt_s = out_valid_r;
        out_last_nxt_s  = out_last_r;
        out_limb_nxt_s  = out_limb_r;
        buf_we_s        = 1'b0;
        buf_wdata_s     = 64'd0;

        p_cur_s   = p_limb(cnt_r);
        t_s       = in_limb - p_cur_s + c_r;
        u_s       = buf_r[cnt_r] + (p_cur_s & m_r) + c_r;
        c_sub_s   = 64'($signed(t_s) >>> RADIX);
        c_add_s   = 64'($signed(u_s) >>> RADIX);
        m_new_s   = {64{t_s[63]}};
        idx_nxt_s = (cnt_r < LAST_IDX) ? (cnt_r + 4'd1) : 4'd0;
        u_nxt_s   = buf_r[idx_nxt_s] + (p_limb(idx_nxt_s) & m_r) + c_add_s;
        // Carry into limb 0 is always zero, so only the new mask matters here.
        u_first_s = buf_r[0] + (p_limb(4'd0) & m_new_s);

        case (state_r)
            S_SUB: begin
                if (in_valid) begin
                    buf_we_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        buf_wdata_s     = t_s;
                        m_nxt_s         = m_new_s;
                        c_nxt_s         = 64'd0;
                        cnt_nxt_s       = 4'd0;
                        state_nxt_s     = S_ADD;
                        in_ready_nxt_s  = 1'b0;
                        out_valid_nxt_s = 1'b1;
                        out_last_nxt_s  = 1'b0;
                        out_limb_nxt_s  = u_first_s & LIMB_MASK;
                    end else begin
                        buf_wdata_s = t_s & LIMB_MASK;
                        c_nxt_s     = c_sub_s;
                        cnt_nxt_s   = cnt_r + 4'd1;
                    end
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            S_ADD: begin
                if (out_ready) begin
                    if (cnt_r == LAST_IDX) begin
                        cnt_nxt_s       = 4'd0;
                        c_nxt_s         = 64'd0;
                        state_nxt_s     = S_SUB;
                        in_ready_nxt_s  = 1'b1;
                        out_valid_nxt_s = 1'b0;
                        out_last_nxt_s  = 1'b0;
                        out_limb_nxt_s  = 64'd0;
                    end else begin
                        c_nxt_s   = c_add_s;
                        cnt_nxt_s = cnt_r + 4'd1;
                        if (idx_nxt_s == LAST_IDX) begin
                            out_limb_nxt_s = u_nxt_s;
                            out_last_nxt_s = 1'b1;
                        end else begin
                            out_limb_nxt_s = u_nxt_s & LIMB_MASK;
                            out_last_nxt_s = 1'b0;
                        end
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s     = S_SUB;
                cnt_nxt_s       = 4'd0;
                c_nxt_s         = 64'd0;
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
                out_last_nxt_s  = 1'b0;
                out_limb_nxt_s  = 64'd0;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_r     <= S_SUB;
            cnt_r       <= 4'd0;
            c_r         <= 64'd0;
            m_r         <= 64'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_limb_r  <= 64'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            c_r         <= c_nxt_s;
            m_r         <= m_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_limb_r  <= out_limb_nxt_s;
        end
    end

    // Limb buffer holds data only; every element rewrites it before reading, so no reset.
    always_ff @(posedge g_clk) begin
        if (buf_we_s) begin
            buf_r[cnt_r] <= buf_wdata_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_limb  = out_limb_r;

endmodule

// File: tb/tb_csidh_modred_seq.sv
// Directed bench for csidh_modred_seq: hand-derived reductions of 0, p, p-1 and p+5,
// plus backpressure, input gaps and a mid-element reset.
module tb_csidh_modred_seq;

    logic        g_clk;
    logic        g_resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_limb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_limb;
    logic        out_last;

    int n_cmp;
    int n_err;

    logic [63:0] p_tab [9];
    logic [63:0] vec   [9];
    logic [63:0] expv  [9];

    csidh_modred_seq dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_limb   (in_limb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_limb  (out_limb),
        .out_last  (out_last)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic send_vec(input bit gaps);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_limb  = vec[i];
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL in_ready limb %0d: got %b want 1", i, in_ready);
            end
            @(posedge g_clk); #1;
            in_valid = 1'b0;
            in_limb  = 64'd0;
            if (gaps && i < 8) begin
                @(posedge g_clk); #1;
            end
        end
    endtask

    // Expects to be entered #1 after the limb-8 handshake edge.
    task automatic recv_vec(input string name, input int stall_at, input int stall_len);
        logic exp_last;
        in_valid = 1'b1;
        in_limb  = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 9; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    n_cmp++;
                    if (out_valid !== 1'b1 || out_limb !== expv[i]) begin
                        n_err++;
                        $display("FAIL %s stall %0d limb %0d: got v=%b %h want v=1 %h",
                                 name, s, i, out_valid, out_limb, expv[i]);
                    end
                    @(posedge g_clk); #1;
                end
                out_ready = 1'b1;
            end
            exp_last = (i == 8);
            n_cmp++;
            if (out_valid !== 1'b1 || out_limb !== expv[i] || out_last !== exp_last
                || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s limb %0d: got v=%b limb=%h last=%b rdy=%b want v=1 limb=%h last=%b rdy=0",
                         name, i, out_valid, out_limb, out_last, in_ready, expv[i], exp_last);
            end
            @(posedge g_clk); #1;
        end
        in_valid = 1'b0;
        in_limb  = 64'd0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s end: got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        g_resetn  = 1'b0;
        in_valid  = 1'b0;
        in_limb   = 64'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge g_clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_limb !== 64'd0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b v=%b last=%b limb=%h want 1 0 0 0",
                     in_ready, out_valid, out_last, out_limb);
        end
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
    endtask

    task automatic test_zero();
        for (int i = 0; i < 9; i++) begin
            vec[i]  = 64'd0;
            expv[i] = 64'd0;
        end
        send_vec(1'b0);
        recv_vec("zero", -1, 0);
    endtask

    task automatic test_p();
        for (int i = 0; i < 9; i++) begin
            vec[i]  = p_tab[i];
            expv[i] = 64'd0;
        end
        send_vec(1'b0);
        recv_vec("a_eq_p", -1, 0);
    endtask

    task automatic test_p_minus_1();
        for (int i = 0; i < 9; i++) begin
            vec[i]  = p_tab[i];
            expv[i] = p_tab[i];
        end
        vec[0]  = 64'h0181B90533C6C87A;
        expv[0] = 64'h0181B90533C6C87A;
        send_vec(1'b0);
        recv_vec("p_minus_1", -1, 0);
    endtask

    task automatic load_p_plus_5();
        for (int i = 0; i < 9; i++) begin
            vec[i]  = p_tab[i];
            expv[i] = 64'd0;
        end
        vec[0]  = 64'h0181B90533C6C880;
        expv[0] = 64'd5;
    endtask

    task automatic test_p_plus_5();
        load_p_plus_5();
        send_vec(1'b0);
        recv_vec("p_plus_5", -1, 0);
    endtask

    task automatic test_backpressure();
        load_p_plus_5();
        send_vec(1'b0);
        recv_vec("backpressure", 4, 3);
    endtask

    task automatic test_in_gaps();
        load_p_plus_5();
        send_vec(1'b1);
        recv_vec("in_gaps", -1, 0);
    endtask

    task automatic test_reset_mid();
        // Partial element of a = 0 limbs; would yield a different result if not discarded.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_limb  = 64'd0;
            @(posedge g_clk); #1;
        end
        in_valid = 1'b0;
        g_resetn = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        load_p_plus_5();
        send_vec(1'b0);
        recv_vec("reset_mid", -1, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        p_tab[0] = 64'h0181B90533C6C87B;
        p_tab[1] = 64'h010DFA2BD6541A8D;
        p_tab[2] = 64'h003307C2D3C9709C;
        p_tab[3] = 64'h00ACFE6AA0EA2CE6;
        p_tab[4] = 64'h01322C9CDA7AAC6C;
        p_tab[5] = 64'h00446212D7DFE634;
        p_tab[6] = 64'h01312AD0B420EBB7;
        p_tab[7] = 64'h017FF91561A2BC7C;
        p_tab[8] = 64'h0065B48E8F740F89;

        test_reset();
        test_zero();
        test_p();
        test_p_minus_1();
        test_p_plus_5();
        test_backpressure();
        test_in_gaps();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
